// File: rtl/gf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gf_pkg
// Purpose  : Shared GF(2^m) constants, FSM state type and xtime helper.
// Revision : 1.0 - initial release
// ============================================================================
package gf_pkg;

  localparam logic [7:0] GF8_AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gf_state_e;

  // Multiply s by x modulo (x^width + poly); operands live in the low width bits.
  function automatic logic [31:0] gf_xtime(input logic [31:0] s,
                                           input logic [31:0] poly,
                                           input int unsigned width);
    logic [31:0] mask;
    logic [31:0] sh;
    logic        msb;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    msb  = |(s & (32'd1 << (width - 32'd1)));
    sh   = (s << 1) & mask;
    if (msb) sh = sh ^ (poly & mask);
    return sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf_digit_step.sv
`default_nettype none
// ============================================================================
// Module   : gf_digit_step
// Purpose  : DIGIT unrolled shift-and-add steps of an LSB-first GF multiply.
// Revision : 1.0 - initial release
// ============================================================================
module gf_digit_step
  import gf_pkg::*;
#(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   POLY  = WIDTH'(GF8_AES_POLY),
  parameter int                 DIGIT = 1
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sa,
  input  logic [WIDTH-1:0] sb,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] sa_nxt,
  output logic [WIDTH-1:0] sb_nxt
);

  logic [WIDTH-1:0] w_acc [DIGIT+1];
  logic [WIDTH-1:0] w_sa  [DIGIT+1];
  logic [WIDTH-1:0] w_sb  [DIGIT+1];

  assign w_acc[0] = acc;
  assign w_sa[0]  = sa;
  assign w_sb[0]  = sb;

  for (genvar i = 0; i < DIGIT; i++) begin : g_step
    assign w_acc[i+1] = w_sb[i][0] ? (w_acc[i] ^ w_sa[i]) : w_acc[i];
    assign w_sa[i+1]  = WIDTH'(gf_xtime(32'(w_sa[i]), 32'(POLY), WIDTH));
    assign w_sb[i+1]  = w_sb[i] >> 1;
  end

  assign acc_nxt = w_acc[DIGIT];
  assign sa_nxt  = w_sa[DIGIT];
  assign sb_nxt  = w_sb[DIGIT];

endmodule
`default_nettype wire

// File: rtl/gf_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : gf_mult_seq
// Purpose  : Iterative GF(2^WIDTH) multiplier, DIGIT bits/cycle, fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module gf_mult_seq
  import gf_pkg::*;
#(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   POLY  = WIDTH'(GF8_AES_POLY),
  parameter int                 DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic             busy
);

  localparam int c_steps = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int c_cnt_w = (c_steps > 1) ? $clog2(c_steps) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_steps - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("gf_mult_seq: WIDTH must lie in 2..32");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("gf_mult_seq: DIGIT must divide WIDTH");
  end

  gf_state_e          r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_acc, r_sa, r_sb, r_p;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   w_acc_nxt, w_sa_nxt, w_sb_nxt;
  logic               w_last;

  gf_digit_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .DIGIT (DIGIT)
  ) u_step (
    .acc     (r_acc),
    .sa      (r_sa),
    .sb      (r_sb),
    .acc_nxt (w_acc_nxt),
    .sa_nxt  (w_sa_nxt),
    .sb_nxt  (w_sb_nxt)
  );

  assign w_last = (r_cnt == c_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = BUSY;
      BUSY:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Every BUSY cycle runs the full digit step so latency never depends on sb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_sa  <= '0;
      r_sb  <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sa  <= a;
            r_sb  <= b;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        BUSY: begin
          r_acc <= w_acc_nxt;
          r_sa  <= w_sa_nxt;
          r_sb  <= w_sb_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_p <= w_acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign p         = r_p;

endmodule
`default_nettype wire
